// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, limits and parity helper for the framed UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {PARITY_NONE, PARITY_EVEN, PARITY_ODD} parity_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int MIN_DATA_BITS = 5;
    localparam int MAX_DATA_BITS = 9;
    localparam int MAX_STOP_BITS = 2;

    // Zero-extension above the payload leaves the reduction unchanged.
    function automatic logic parity_bit(parity_t mode, logic [MAX_DATA_BITS-1:0] data);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_framed_if.sv
// rtl/uart_tx_framed_if.sv - stream sink bundle carrying words into the UART transmitter
interface uart_tx_framed_if #(
    parameter int data_bits = 8
) ();
    logic                 tvalid;
    logic                 tready;
    logic [data_bits-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous show-ahead FIFO buffering words ahead of the framer
module uart_tx_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [width-1:0]       wdata,
    input  logic                   pop,
    output logic [width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] level
);
    localparam int AW = $clog2(depth);
    localparam int LW = AW + 1;

    logic [width-1:0] mem [depth];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + LW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Extra pointer bit distinguishes full from empty.
    assign rdata = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LW'(depth));
    assign empty = (level == '0);

endmodule

// File: rtl/uart_tx_framed.sv
// rtl/uart_tx_framed.sv - framing FSM serialising buffered stream words onto the tx pad
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int      cycles_per_bit = 434,
    parameter int      data_bits      = 8,
    parameter parity_t parity         = PARITY_NONE,
    parameter int      stop_bits      = 1,
    parameter int      fifo_depth     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_tx_framed_if.slave             s_axis,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(fifo_depth):0] fifo_level
);
    localparam int CW = $clog2(cycles_per_bit);
    localparam int IW = $clog2(data_bits + 1);
    localparam int LW = $clog2(fifo_depth) + 1;

    if (data_bits < MIN_DATA_BITS || data_bits > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_framed: data_bits must be within 5..9");
    end
    if (stop_bits < 1 || stop_bits > MAX_STOP_BITS) begin : g_bad_stop_bits
        $error("uart_tx_framed: stop_bits must be 1 or 2");
    end
    if (cycles_per_bit < 2) begin : g_bad_cycles
        $error("uart_tx_framed: cycles_per_bit must be at least 2");
    end
    if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_framed: fifo_depth must be a power of two >= 2");
    end

    tx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [data_bits-1:0] shreg, shreg_n;
    logic                 par, par_n;
    logic                 tx_n, busy_n, tready, tready_n;
    logic                 push, pop, full, empty, last_cyc;
    logic [data_bits-1:0] rdata;
    logic [LW-1:0]        level_n;

    assign push          = s_axis.tvalid && tready && !full;
    assign s_axis.tready = tready;
    assign last_cyc      = (cnt == CW'(cycles_per_bit - 1));
    assign level_n       = fifo_level + LW'(push) - LW'(pop);

    uart_tx_fifo #(.width(data_bits), .depth(fifo_depth)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (s_axis.tdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            tx     <= 1'b1;
            busy   <= 1'b0;
            tready <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shreg  <= shreg_n;
            par    <= par_n;
            tx     <= tx_n;
            busy   <= busy_n;
            tready <= tready_n;
        end
    end

    // tx is registered from the current state, so the line trails the FSM by one clock.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shreg_n  = shreg;
        par_n    = par;
        pop      = 1'b0;
        tx_n     = 1'b1;
        busy_n   = (state != IDLE) || !empty;
        tready_n = (level_n != LW'(fifo_depth));
        if (state != IDLE) cnt_n = last_cyc ? '0 : cnt + CW'(1);
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (last_cyc) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                tx_n = shreg[0];
                if (last_cyc) begin
                    shreg_n = shreg >> 1;
                    if (idx == IW'(data_bits - 1)) begin
                        idx_n   = '0;
                        state_n = (parity == PARITY_NONE) ? STOP : PARITY;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            PARITY: begin
                tx_n = par;
                if (last_cyc) begin
                    state_n = STOP;
                    idx_n   = '0;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (last_cyc) begin
                    if (idx == IW'(stop_bits - 1)) begin
                        idx_n = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (pop) begin
            shreg_n = rdata;
            par_n   = parity_bit(parity, MAX_DATA_BITS'(rdata));
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// tb/tb_uart_tx_framed.sv - self-checking bench for uart_tx_framed over several parameter sets
module tb_uart_tx_framed;
    import uart_pkg::*;

    localparam int NI = 5;
    localparam int      CFG_CPB   [NI] = '{4, 4, 4, 4, 2};
    localparam int      CFG_D     [NI] = '{8, 8, 8, 5, 9};
    localparam parity_t CFG_PAR   [NI] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_NONE, PARITY_EVEN};
    localparam int      CFG_STOP  [NI] = '{1, 1, 2, 1, 2};
    localparam int      CFG_DEPTH [NI] = '{4, 4, 4, 4, 2};

    logic            clk;
    logic            rst_n;
    logic [NI-1:0]   tvalid_w;
    logic [NI-1:0]   tready_w;
    logic [NI-1:0]   tx_w;
    logic [NI-1:0]   busy_w;
    logic [8:0]      tdata_w [NI];
    logic [NI*4-1:0] level_flat;
    logic [8:0]      exp_q [NI][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int push_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at cycle %0d", name, i, act, exp, cyc);
        end
    endtask

    function automatic int lvl(input int i);
        return int'(level_flat[i*4 +: 4]);
    endfunction

    function automatic logic [8:0] mask_of(input int i);
        return 9'((1 << CFG_D[i]) - 1);
    endfunction

    // Receiver decode of one frame of mid-bit samples, in send order.
    task automatic rx_frame(input int g, input logic [12:0] b);
        logic [8:0] w;
        logic [8:0] e;
        int p;
        w = '0;
        for (int j = 0; j < CFG_D[g]; j++) w[j] = b[1 + j];
        check("rx_start", g, 32'(b[0]), 32'd0);
        p = 1 + CFG_D[g];
        if (CFG_PAR[g] != PARITY_NONE) begin
            check("rx_parity", g, 32'(b[p]), 32'((CFG_PAR[g] == PARITY_ODD) ? ~^w : ^w));
            p++;
        end
        for (int s = 0; s < CFG_STOP[g]; s++) check("rx_stop", g, 32'(b[p + s]), 32'd1);
        if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected inst%0d: got word 0x%0h expected none", g, w);
        end else begin
            e = exp_q[g].pop_front();
            check("rx_data", g, 32'(w), 32'(e));
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int C  = CFG_CPB[g];
        localparam int D  = CFG_D[g];
        localparam int NB = 1 + D + ((CFG_PAR[g] != PARITY_NONE) ? 1 : 0) + CFG_STOP[g];

        uart_tx_framed_if #(.data_bits(D)) ifc ();
        logic [$clog2(CFG_DEPTH[g]):0] lvl_g;

        assign ifc.tvalid            = tvalid_w[g];
        assign ifc.tdata             = tdata_w[g][D-1:0];
        assign tready_w[g]           = ifc.tready;
        assign level_flat[g*4 +: 4]  = 4'(lvl_g);

        uart_tx_framed #(
            .cycles_per_bit (C),
            .data_bits      (D),
            .parity         (CFG_PAR[g]),
            .stop_bits      (CFG_STOP[g]),
            .fifo_depth     (CFG_DEPTH[g])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .s_axis     (ifc),
            .tx         (tx_w[g]),
            .busy       (busy_w[g]),
            .fifo_level (lvl_g)
        );

        initial begin : rx_model
            int t;
            logic [12:0] bits;
            bit active;
            active = 1'b0;
            t = 0;
            bits = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    active = 1'b0;
                    exp_q[g].delete();
                end else begin
                    if (!active && !tx_w[g]) begin
                        active = 1'b1;
                        t = 0;
                    end
                    if (active) begin
                        if (t % C == C / 2) bits[t / C] = tx_w[g];
                        if (t == (NB - 1) * C + C / 2) begin
                            active = 1'b0;
                            rx_frame(g, bits);
                        end
                        t++;
                    end
                end
            end
        end
    end

    // Entered and left at a falling edge; push_cyc records the accepting edge.
    task automatic push_word(input int i, input logic [8:0] d);
        int guard;
        guard = 0;
        tvalid_w[i] = 1'b1;
        tdata_w[i] = d;
        while (!tready_w[i] && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            checks++;
            errors++;
            $display("FAIL push_timeout inst%0d: got tready 0 expected 1 within 3000 cycles", i);
        end else begin
            exp_q[i].push_back(d & mask_of(i));
            @(negedge clk);
            push_cyc = cyc;
        end
        tvalid_w[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((busy_w[i] || !tx_w[i] || lvl(i) != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout inst%0d: got busy %0b expected 0 within 5000 cycles", i, busy_w[i]);
        end
    endtask

    typedef struct {
        int         inst;
        logic [8:0] data;
        string      pattern;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int c;
        c = CFG_CPB[v.inst];
        wait_idle(v.inst);
        push_word(v.inst, v.data);
        check("lat_level", v.inst, 32'(lvl(v.inst)), 32'd1);
        check("lat_tx_k", v.inst, 32'(tx_w[v.inst]), 32'd1);
        @(negedge clk);
        check("lat_tx_k1", v.inst, 32'(tx_w[v.inst]), 32'd1);
        check("lat_busy", v.inst, 32'(busy_w[v.inst]), 32'd1);
        for (int b = 0; b < v.pattern.len(); b++) begin
            for (int k = 0; k < c; k++) begin
                @(negedge clk);
                check("frame_bit", v.inst, 32'(tx_w[v.inst]), 32'(v.pattern[b] == "1"));
            end
        end
        @(negedge clk);
        check("end_tx", v.inst, 32'(tx_w[v.inst]), 32'd1);
        check("end_busy", v.inst, 32'(busy_w[v.inst]), 32'd0);
    endtask

    vec_t vecs [8];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k0;
        int n;
        vecs[0] = '{0, 9'h0A5, "0101001011"};
        vecs[1] = '{1, 9'h0A5, "01010010101"};
        vecs[2] = '{2, 9'h0A5, "010100101111"};
        vecs[3] = '{3, 9'h01F, "0111111"};
        vecs[4] = '{0, 9'h000, "0000000001"};
        vecs[5] = '{1, 9'h001, "01000000011"};
        vecs[6] = '{2, 9'h0FF, "011111111111"};
        vecs[7] = '{4, 9'h155, "0101010101111"};

        rst_n = 1'b0;
        tvalid_w = '0;
        for (int i = 0; i < NI; i++) tdata_w[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_tx", i, 32'(tx_w[i]), 32'd1);
            check("rst_tready", i, 32'(tready_w[i]), 32'd1);
            check("rst_busy", i, 32'(busy_w[i]), 32'd0);
            check("rst_level", i, 32'(lvl(i)), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[v]) run_vec(vecs[v]);

        // Reset asserted between edges while data bit 0 of 0x3C (a zero) is on the line.
        wait_idle(0);
        push_word(0, 9'h03C);
        repeat (6) @(negedge clk);
        check("pre_reset_tx", 0, 32'(tx_w[0]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx", 0, 32'(tx_w[0]), 32'd1);
        check("midrst_busy", 0, 32'(busy_w[0]), 32'd0);
        check("midrst_tready", 0, 32'(tready_w[0]), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (tx_w[0] && !busy_w[0]) n++;
        end
        check("postrst_idle_cycles", 0, 32'(n), 32'd12);

        // Burst of six words with tvalid held: FIFO fills, frames run back to back.
        wait_idle(0);
        push_word(0, 9'h000);
        k0 = push_cyc;
        for (int w = 1; w < 6; w++) begin
            push_word(0, 9'(w));
            if (w == 4) begin
                check("burst_level_full", 0, 32'(lvl(0)), 32'd4);
                check("burst_tready_low", 0, 32'(tready_w[0]), 32'd0);
            end
        end
        check("burst_push5_cycle", 0, 32'(push_cyc - k0), 32'(1 + 10 * 4 + 1));
        n = 0;
        while (busy_w[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("burst_busy_fall", 0, 32'(cyc - k0), 32'(2 + 6 * 10 * 4));

        for (int i = 0; i < NI; i++) begin
            wait_idle(i);
            for (int w = 0; w < 40; w++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push_word(i, 9'($urandom));
            end
        end
        for (int i = 0; i < NI; i++) begin
            wait_idle(i);
            check("drain_queue", i, 32'(exp_q[i].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
